// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit
// Brief    : Writeback commit stage with an 8 x DATA_W register file, two
//            bypassed combinational read ports, MEM/IO pending tracking with
//            timeout, and a load-use hazard flag.
// Revision : 1.0  initial release
// ============================================================================
module wb_commit #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_sel,
    input  logic [2:0]        req_rd,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_data,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              io_rvalid,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic [2:0]        rs1_addr,
    input  logic [2:0]        rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              hazard,
    output logic              err_spurious,
    output logic              err_timeout
);

    localparam logic [2:0] SEL_MEM  = 3'b010;
    localparam logic [2:0] SEL_IO   = 3'b011;
    // Last counter value before the wait is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WAIT_IO  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        pend_rd;
    logic              pend_we;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] rf [0:7];

    logic              accept;
    logic              sel_mem;
    logic              sel_io;
    logic              mem_done;
    logic              io_done;
    logic              resp_done;
    logic              timeout_hit;
    logic              spurious;

    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid & req_ready;
    assign sel_mem     = (req_sel == SEL_MEM);
    assign sel_io      = (req_sel == SEL_IO);
    assign mem_done    = (state == WAIT_MEM) & mem_rvalid;
    assign io_done     = (state == WAIT_IO) & io_rvalid;
    assign resp_done   = mem_done | io_done;
    // A response on the last wait cycle takes priority over the timeout.
    assign timeout_hit = (state != IDLE) & ~resp_done & (wait_cnt == CNT_LAST);
    // A response is spurious unless the FSM is waiting on that exact source.
    assign spurious    = (mem_rvalid & (state != WAIT_MEM)) |
                         (io_rvalid  & (state != WAIT_IO));

    // Next-state logic: IDLE dispatches, wait states end on response or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && sel_mem) begin
                    state_nxt = WAIT_MEM;
                end else if (accept && sel_io) begin
                    state_nxt = WAIT_IO;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_IO: begin
                if (io_rvalid || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single register-file write port shared by direct commits and responses.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = '0;
        if (!rst) begin
            if (accept && !sel_mem && !sel_io) begin
                wr_en   = req_we & (req_rd != 3'd0);
                wr_addr = req_rd;
                wr_data = req_data;
            end else if (mem_done) begin
                wr_en   = pend_we;
                wr_addr = pend_rd;
                wr_data = mem_rdata;
            end else if (io_done) begin
                wr_en   = pend_we;
                wr_addr = pend_rd;
                wr_data = io_rdata;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending destination capture and wait-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_rd  <= 3'd0;
            pend_we  <= 1'b0;
            wait_cnt <= 8'd0;
        end else if (accept && (sel_mem || sel_io)) begin
            pend_rd  <= req_rd;
            pend_we  <= req_we & (req_rd != 3'd0);
            wait_cnt <= 8'd0;
        end else if ((state != IDLE) && !resp_done) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_spurious <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (spurious) begin
                err_spurious <= 1'b1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // Register file storage; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    // Read port 1 with same-cycle write bypass.
    always_comb begin
        rs1_data = rf[rs1_addr];
        if (rs1_addr == 3'd0) begin
            rs1_data = '0;
        end else if (wr_en && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end
    end

    // Read port 2 with same-cycle write bypass.
    always_comb begin
        rs2_data = rf[rs2_addr];
        if (rs2_addr == 3'd0) begin
            rs2_data = '0;
        end else if (wr_en && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
    end

    // Load-use hazard; dropped in the response cycle since bypass covers it.
    always_comb begin
        hazard = (state != IDLE) & pend_we & ~resp_done &
                 ((rs1_addr == pend_rd) | (rs2_addr == pend_rd));
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit
// Brief    : Self-checking bench for wb_commit (vector table + scoreboard).
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sel;
    logic [2:0]  req_rd;
    logic        req_we;
    logic [15:0] req_data;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        io_rvalid;
    logic [15:0] io_rdata;
    logic [2:0]  rs1_addr;
    logic [2:0]  rs2_addr;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        hazard;
    logic        err_spurious;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  rd;
        logic        we;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] val;
    } sb_t;

    vec_t vecs [7];
    sb_t  q [$];
    sb_t  sb;

    wb_commit #(.DATA_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_rd(req_rd), .req_we(req_we), .req_data(req_data),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .hazard(hazard), .err_spurious(err_spurious), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] sel, input logic [2:0] rd,
                         input logic we, input logic [15:0] data);
        req_valid = 1'b1;
        req_sel   = sel;
        req_rd    = rd;
        req_we    = we;
        req_data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b000, 3'd3, 1'b1, 16'h1234, 16'h1234};
        vecs[1] = '{3'b001, 3'd0, 1'b1, 16'hBEEF, 16'h0000};
        vecs[2] = '{3'b100, 3'd1, 1'b1, 16'h0042, 16'h0042};
        vecs[3] = '{3'b101, 3'd7, 1'b0, 16'hFFFF, 16'h0000};
        vecs[4] = '{3'b110, 3'd6, 1'b1, 16'hC0DE, 16'hC0DE};
        vecs[5] = '{3'b111, 3'd3, 1'b1, 16'h5678, 16'h5678};
        vecs[6] = '{3'b101, 3'd7, 1'b1, 16'hABCD, 16'hABCD};

        rst = 1'b1; req_valid = 1'b0; req_sel = 3'd0; req_rd = 3'd0; req_we = 1'b0;
        req_data = 16'h0; mem_rvalid = 1'b0; mem_rdata = 16'h0; io_rvalid = 1'b0;
        io_rdata = 16'h0; rs1_addr = 3'd0; rs2_addr = 3'd0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Reset state
        #1;
        chk("rst_ready", {15'd0, req_ready}, 16'd1);
        chk("rst_hazard", {15'd0, hazard}, 16'd0);
        chk("rst_err_sp", {15'd0, err_spurious}, 16'd0);
        chk("rst_err_to", {15'd0, err_timeout}, 16'd0);
        for (int a = 0; a < 8; a++) begin
            rs1_addr = 3'(a);
            rs2_addr = 3'(7 - a);
            #1;
            chk("rst_rs1", rs1_data, 16'h0);
            chk("rst_rs2", rs2_data, 16'h0);
        end

        // Single-cycle commits from the vector table
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].sel, vecs[i].rd, vecs[i].we, vecs[i].data);
            rs1_addr = vecs[i].rd;
            #1;
            chk("vec_ready", {15'd0, req_ready}, 16'd1);
            chk("vec_bypass", rs1_data, vecs[i].exp);
            q.push_back('{vecs[i].rd, vecs[i].exp});
            step();
            req_valid = 1'b0;
            sb = q.pop_front();
            rs1_addr = sb.rd;
            #1;
            chk("vec_rf", rs1_data, sb.val);
        end

        // MEM load, response in the third wait cycle
        issue(3'b010, 3'd5, 1'b1, 16'hFFFF);
        rs1_addr = 3'd0;
        rs2_addr = 3'd5;
        #1;
        chk("mem_acc_ready", {15'd0, req_ready}, 16'd1);
        step();
        req_valid = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            if (w == 3) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 16'hA5A5;
                q.push_back('{3'd5, 16'hA5A5});
            end
            #1;
            chk("mem_wait_ready", {15'd0, req_ready}, 16'd0);
            chk("mem_hazard", {15'd0, hazard}, (w < 3) ? 16'd1 : 16'd0);
            if (w == 3) chk("mem_bypass", rs2_data, 16'hA5A5);
            step();
        end
        mem_rvalid = 1'b0;
        #1;
        chk("mem_done_ready", {15'd0, req_ready}, 16'd1);
        sb = q.pop_front();
        rs2_addr = sb.rd;
        #1;
        chk("mem_rf", rs2_data, sb.val);
        chk("mem_err_sp", {15'd0, err_spurious}, 16'd0);
        chk("mem_err_to", {15'd0, err_timeout}, 16'd0);
        chk("mem_hazard_idle", {15'd0, hazard}, 16'd0);

        // Cross response: io_rvalid alongside mem_rvalid in WAIT_MEM
        issue(3'b010, 3'd4, 1'b1, 16'h0000);
        #1;
        step();
        req_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 16'h0F0F;
        io_rvalid  = 1'b1; io_rdata  = 16'h1111;
        rs1_addr = 3'd4;
        #1;
        chk("cross_bypass", rs1_data, 16'h0F0F);
        step();
        mem_rvalid = 1'b0; io_rvalid = 1'b0;
        #1;
        chk("cross_rf", rs1_data, 16'h0F0F);
        chk("cross_err_sp", {15'd0, err_spurious}, 16'd1);
        chk("cross_ready", {15'd0, req_ready}, 16'd1);

        // Reset clears flags and registers
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst2_err_sp", {15'd0, err_spurious}, 16'd0);
        chk("rst2_r4", rs1_data, 16'h0);

        // Response on the timeout cycle wins
        issue(3'b010, 3'd6, 1'b1, 16'h0000);
        #1;
        step();
        req_valid = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            if (w == 4) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 16'h7E57;
            end
            #1;
            chk("tcyc_ready", {15'd0, req_ready}, 16'd0);
            step();
        end
        mem_rvalid = 1'b0;
        rs1_addr = 3'd6;
        #1;
        chk("tcyc_done_ready", {15'd0, req_ready}, 16'd1);
        chk("tcyc_err_to", {15'd0, err_timeout}, 16'd0);
        chk("tcyc_rf", rs1_data, 16'h7E57);

        // Timeout: IO request with no response
        issue(3'b001, 3'd2, 1'b1, 16'h1111);
        #1;
        step();
        issue(3'b011, 3'd2, 1'b1, 16'h0000);
        rs1_addr = 3'd2;
        #1;
        step();
        req_valid = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            #1;
            chk("to_wait_ready", {15'd0, req_ready}, 16'd0);
            chk("to_hazard", {15'd0, hazard}, 16'd1);
            step();
        end
        #1;
        chk("to_ready", {15'd0, req_ready}, 16'd1);
        chk("to_err_to", {15'd0, err_timeout}, 16'd1);
        chk("to_err_sp", {15'd0, err_spurious}, 16'd0);
        chk("to_r2", rs1_data, 16'h1111);
        io_rvalid = 1'b1; io_rdata = 16'hDEAD;
        #1;
        chk("late_nobypass", rs1_data, 16'h1111);
        step();
        io_rvalid = 1'b0;
        #1;
        chk("late_err_sp", {15'd0, err_spurious}, 16'd1);
        chk("late_r2", rs1_data, 16'h1111);

        // Reset mid-wait with io_rvalid held during reset
        issue(3'b011, 3'd1, 1'b1, 16'h0000);
        #1;
        step();
        req_valid = 1'b0;
        #1;
        chk("rmw_wait_ready", {15'd0, req_ready}, 16'd0);
        rst = 1'b1; io_rvalid = 1'b1; io_rdata = 16'h9999;
        step();
        step();
        rst = 1'b0; io_rvalid = 1'b0;
        rs1_addr = 3'd1; rs2_addr = 3'd2;
        #1;
        chk("rmw_ready", {15'd0, req_ready}, 16'd1);
        chk("rmw_err_sp", {15'd0, err_spurious}, 16'd0);
        chk("rmw_err_to", {15'd0, err_timeout}, 16'd0);
        chk("rmw_hazard", {15'd0, hazard}, 16'd0);
        chk("rmw_r1", rs1_data, 16'h0);
        chk("rmw_r2", rs2_data, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
